// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types, constants and helpers for the rate-1/2 Viterbi decoder
package viterbi_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ACS, ST_TRACE, ST_OUT} vit_state_e;

   localparam logic [3:0] G0_DEFAULT = 4'b1111;
   localparam logic [3:0] G1_DEFAULT = 4'b1101;

   function automatic logic parity(input logic [7:0] x);
      return ^x;
   endfunction

   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] d;
      d = a ^ b;
      return {d[1] & d[0], d[1] ^ d[0]};
   endfunction

   // Metric must hold 2N without saturating, plus headroom for the all-ones init value.
   function automatic int metric_width(input int n);
      return $clog2(2 * n + 1) + 1;
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// rtl/viterbi_acs.sv - add-compare-select for one trellis state
module viterbi_acs #(
   parameter int W = 6
) (
   input  logic [W-1:0] pm0,
   input  logic [W-1:0] pm1,
   input  logic [1:0]   bm0,
   input  logic [1:0]   bm1,
   output logic [W-1:0] pm_new,
   output logic         dec
);

   logic [W:0]   sum0;
   logic [W:0]   sum1;
   logic [W-1:0] cand0;
   logic [W-1:0] cand1;

   always_comb begin
      sum0   = {1'b0, pm0} + {{(W-1){1'b0}}, bm0};
      sum1   = {1'b0, pm1} + {{(W-1){1'b0}}, bm1};
      cand0  = sum0[W] ? '1 : sum0[W-1:0];
      cand1  = sum1[W] ? '1 : sum1[W-1:0];
      // Strict compare so that a tie selects the b=0 predecessor.
      dec    = (cand1 < cand0);
      pm_new = dec ? cand1 : cand0;
   end

endmodule

// File: rtl/viterbi_param.sv
// rtl/viterbi_param.sv - parametrised hard-decision Viterbi decoder, whole-frame in, decoded frame out
module viterbi_param
   import viterbi_pkg::*;
#(
   parameter int           N    = 14,
   parameter int           K    = 4,
   parameter logic [K-1:0] G0   = G0_DEFAULT,
   parameter logic [K-1:0] G1   = G1_DEFAULT,
   parameter bit           TERM = 1'b1,
   localparam int          MW   = metric_width(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   data,
   output logic [MW-1:0]  metric,
   output logic           done
);

   localparam int            S      = 1 << (K - 1);
   localparam int            SBW    = K - 1;
   localparam int            SW     = $clog2(N);
   localparam logic [MW-1:0] PM_SAT = '1;

   vit_state_e     state_q, state_d;
   logic [SW-1:0]  step_q, step_d;
   logic [2*N-1:0] frame_q, frame_d;
   logic [MW-1:0]  pm_q [S];
   logic [MW-1:0]  pm_d [S];
   logic [S-1:0]   dec_q [N];
   logic [S-1:0]   dec_d [N];
   logic [SBW-1:0] ts_q, ts_d;
   logic [N-1:0]   data_q, data_d;
   logic [MW-1:0]  metric_q, metric_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           done_q, done_d;

   logic [1:0]     pair;
   logic [MW-1:0]  acs_pm [S];
   logic [S-1:0]   acs_dec;
   logic [MW-1:0]  best_pm;
   logic [SBW-1:0] best_state;
   logic [SBW-1:0] start_state;
   logic [SBW-1:0] cur_state;
   logic [SBW-1:0] prev_state;

   always_comb begin
      pair = frame_q[(2 * N - 2) - 2 * int'(step_q) +: 2];
   end

   // Predecessors of s' are {s'[K-3:0], b}, so the encoder register is r = {s', b}.
   for (genvar sp = 0; sp < S; sp++) begin : g_acs
      localparam logic [7:0] R0   = 8'(2 * sp);
      localparam logic [7:0] R1   = 8'(2 * sp + 1);
      localparam logic [1:0] EXP0 = {parity(R0 & 8'(G0)), parity(R0 & 8'(G1))};
      localparam logic [1:0] EXP1 = {parity(R1 & 8'(G0)), parity(R1 & 8'(G1))};
      localparam int         P0   = (2 * sp) % S;
      localparam int         P1   = (2 * sp + 1) % S;

      logic [1:0] bm0;
      logic [1:0] bm1;

      assign bm0 = hamming2(pair, EXP0);
      assign bm1 = hamming2(pair, EXP1);

      viterbi_acs #(.W(MW)) u_acs (
         .pm0    (pm_q[P0]),
         .pm1    (pm_q[P1]),
         .bm0    (bm0),
         .bm1    (bm1),
         .pm_new (acs_pm[sp]),
         .dec    (acs_dec[sp])
      );
   end

   always_comb begin
      best_pm    = pm_q[0];
      best_state = '0;
      for (int i = 1; i < S; i++) begin
         if (pm_q[i] < best_pm) begin
            best_pm    = pm_q[i];
            best_state = SBW'(i);
         end
      end
      start_state = TERM ? '0 : best_state;
      cur_state   = (step_q == SW'(N - 1)) ? start_state : ts_q;
      prev_state  = {cur_state[SBW-2:0], dec_q[step_q][cur_state]};
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      frame_d     = frame_q;
      pm_d        = pm_q;
      dec_d       = dec_q;
      ts_d        = ts_q;
      data_d      = data_q;
      metric_d    = metric_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               frame_d    = in;
               step_d     = '0;
               in_ready_d = 1'b0;
               state_d    = ST_ACS;
               for (int i = 0; i < S; i++) begin
                  pm_d[i] = (i == 0 || !TERM) ? '0 : PM_SAT;
               end
            end
         end
         ST_ACS: begin
            pm_d          = acs_pm;
            dec_d[step_q] = acs_dec;
            if (step_q == SW'(N - 1)) begin
               state_d = ST_TRACE;
            end else begin
               step_d = step_q + SW'(1);
            end
         end
         ST_TRACE: begin
            data_d[(N - 1) - int'(step_q)] = cur_state[SBW-1];
            ts_d                           = prev_state;
            if (step_q == SW'(N - 1)) begin
               metric_d = pm_q[start_state];
            end
            if (step_q == '0) begin
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end else begin
               step_d = step_q - SW'(1);
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         frame_q     <= '0;
         ts_q        <= '0;
         data_q      <= '0;
         metric_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < S; i++) begin
            pm_q[i] <= '0;
         end
         for (int i = 0; i < N; i++) begin
            dec_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         frame_q     <= frame_d;
         ts_q        <= ts_d;
         data_q      <= data_d;
         metric_q    <= metric_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         pm_q        <= pm_d;
         dec_q       <= dec_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data      = data_q;
   assign metric    = metric_q;
   assign done      = done_q;

endmodule

// File: tb/tb_viterbi_param.sv
// tb/tb_viterbi_param.sv - directed self-checking bench for viterbi_param
module tb_viterbi_param;

   localparam logic [27:0] F_ZERO = 28'h0;
   localparam logic [27:0] F_IMP  = 28'b1111101100000000000000000000;
   localparam logic [27:0] F_ERR  = 28'b0111101100000000000000000000;
   localparam logic [13:0] D_IMP  = 14'b10000000000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, done;
   logic [27:0] in_frame;
   logic [13:0] data;
   logic [5:0]  metric;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
   logic [15:0] b_in;
   logic [7:0]  b_data;
   logic [5:0]  b_metric;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   viterbi_param dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_frame),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data      (data),
      .metric    (metric),
      .done      (done)
   );

   viterbi_param #(.N(8), .K(3), .G0(3'b111), .G1(3'b101), .TERM(1'b0)) dut_k3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in        (b_in),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .data      (b_data),
      .metric    (b_metric),
      .done      (b_done)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_main(input logic [27:0] f, output int cyc);
      in_frame = f;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(cyc);
   endtask

   task automatic handshake_main(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, "_done"}, {done, out_valid, in_ready}, 3'b101);
      tick();
      check_eq({tag, "_done_clr"}, done, 1'b0);
   endtask

   function automatic logic [15:0] enc3(input logic [7:0] d);
      logic [1:0]  s;
      logic [2:0]  r;
      logic [15:0] c;
      s = '0;
      c = '0;
      for (int k = 0; k < 8; k++) begin
         r = {d[7-k], s};
         c[15-2*k -: 2] = {^(r & 3'b111), ^(r & 3'b101)};
         s = r[2:1];
      end
      return c;
   endfunction

   initial begin
      int          cyc;
      logic [7:0]  src;
      logic [15:0] code;
      int          nerr;

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_frame = '0;
      b_in_valid = 1'b0;
      b_out_ready = 1'b0;
      b_in = '0;
      tick();
      tick();
      check_eq("rst_outputs", {in_ready, out_valid, done, data, metric}, {1'b1, 1'b0, 1'b0, 14'h0, 6'h0});
      reset = 1'b0;
      tick();

      run_main(F_ZERO, cyc);
      check_eq("zero_latency", cyc, 28);
      check_eq("zero_data", data, 14'h0);
      check_eq("zero_metric", metric, 6'd0);
      check_eq("zero_in_ready", in_ready, 1'b0);
      handshake_main("zero");

      run_main(F_IMP, cyc);
      check_eq("imp_latency", cyc, 28);
      check_eq("imp_data", data, D_IMP);
      check_eq("imp_metric", metric, 6'd0);
      handshake_main("imp");

      run_main(F_ERR, cyc);
      check_eq("err_data", data, D_IMP);
      check_eq("err_metric", metric, 6'd1);
      handshake_main("err");

      // Abort a frame partway through ACS with an asynchronous reset.
      in_frame = F_IMP;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check_eq("pre_rst_busy", {in_ready, out_valid}, 2'b00);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_outputs", {in_ready, out_valid, done, data, metric}, {1'b1, 1'b0, 1'b0, 14'h0, 6'h0});
      tick();
      reset = 1'b0;
      tick();
      check_eq("post_rst_idle", {in_ready, out_valid}, 2'b10);
      run_main(F_ZERO, cyc);
      check_eq("post_rst_latency", cyc, 28);
      check_eq("post_rst_data", data, 14'h0);
      check_eq("post_rst_metric", metric, 6'd0);
      handshake_main("post_rst");

      // Backpressure: result held, input ignored, next frame taken right after the handshake.
      run_main(F_IMP, cyc);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_frame = 28'($urandom);
         check_eq("stall_hold", {out_valid, in_ready, data, metric}, {1'b1, 1'b0, D_IMP, 6'd0});
         tick();
      end
      in_frame = F_ZERO;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp_handshake", {done, out_valid, in_ready}, 3'b101);
      tick();
      in_valid = 1'b0;
      in_frame = F_IMP;
      check_eq("bp_second_accept", {done, in_ready}, 2'b00);
      wait_out(cyc);
      check_eq("bp_second_latency", cyc, 28);
      check_eq("bp_second_data", data, 14'h0);
      check_eq("bp_second_metric", metric, 6'd0);
      handshake_main("bp_second");

      // K=3, N=8, unterminated: at most one channel error per frame, never in the final pair.
      for (int f = 0; f < 6; f++) begin
         src  = 8'($urandom);
         code = enc3(src);
         nerr = 0;
         if (f > 0) begin
            code[$urandom_range(15, 2)] ^= 1'b1;
            nerr = 1;
         end
         b_in = code;
         b_in_valid = 1'b1;
         tick();
         b_in_valid = 1'b0;
         cyc = 0;
         while (!b_out_valid && cyc < 100) begin
            tick();
            cyc++;
         end
         check_eq("k3_latency", cyc, 16);
         check_eq("k3_data", b_data, src);
         check_eq("k3_metric", b_metric, 6'(nerr));
         b_out_ready = 1'b1;
         tick();
         b_out_ready = 1'b0;
         check_eq("k3_done", {b_done, b_in_ready}, 2'b11);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
